// File: rtl/tsetlin_pkg.sv
// Shared definitions for the Tsetlin automaton bank: feedback codes and the
// popcount used to accumulate action flips.
package tsetlin_pkg;

    localparam logic [1:0] FB_NONE    = 2'b00;
    localparam logic [1:0] FB_REWARD  = 2'b01;
    localparam logic [1:0] FB_PENALTY = 2'b10;

    localparam int FLIP_W = 16;
    // Widest flip vector the popcount accepts; callers zero-extend to this.
    localparam int MAX_TA = 256;

    function automatic logic [FLIP_W-1:0] popcount(input logic [MAX_TA-1:0] v);
        logic [FLIP_W-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < MAX_TA; i++) begin
            cnt = cnt + FLIP_W'(v[i]);
        end
        return cnt;
    endfunction

endpackage

// File: rtl/tsetlin_next.sv
// Next-state logic for one Tsetlin automaton. It is purely combinational, and
// its flip output is high when the action bit (the state MSB) would change.
module tsetlin_next
    import tsetlin_pkg::*;
#(
    parameter int STATE_W = 3
) (
    input  logic [STATE_W-1:0] state,
    input  logic [1:0]         fb,
    input  logic               en,
    output logic [STATE_W-1:0] next_state,
    output logic               flip
);

    localparam logic [STATE_W-1:0] MAX = '1;
    localparam logic [STATE_W-1:0] ONE = {{(STATE_W-1){1'b0}}, 1'b1};

    logic act_bit;
    assign act_bit = state[STATE_W-1];

    always_comb begin
        next_state = state;
        if (en) begin
            case (fb)
                FB_REWARD: begin
                    if (act_bit) begin
                        if (state != MAX) next_state = state + ONE;
                    end else begin
                        if (state != '0) next_state = state - ONE;
                    end
                end
                // Penalty never saturates: it always moves toward HALF-1/HALF.
                FB_PENALTY: begin
                    if (act_bit) next_state = state - ONE;
                    else         next_state = state + ONE;
                end
                default: ;
            endcase
        end
        flip = next_state[STATE_W-1] ^ state[STATE_W-1];
    end

endmodule

// File: rtl/tsetlin_bank.sv
// Bank of N_TA Tsetlin automata. It has a valid/ready update port, a broadcast
// mode, an out-of-range index error pulse and a saturating action-flip counter.
module tsetlin_bank
    import tsetlin_pkg::*;
#(
    parameter int N_TA       = 4,
    parameter int STATE_W    = 3,
    parameter int INIT_STATE = 2**(STATE_W-1) - 1,
    parameter int IDX_W      = (N_TA > 1) ? $clog2(N_TA) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               upd_valid,
    output logic               upd_ready,
    input  logic [IDX_W-1:0]   upd_idx,
    input  logic               upd_bcast,
    input  logic [1:0]         upd_fb,
    input  logic               freeze,
    output logic [N_TA-1:0]    action,
    input  logic [IDX_W-1:0]   rd_idx,
    output logic [STATE_W-1:0] rd_state,
    output logic               upd_err,
    output logic [15:0]        flip_cnt
);

    localparam logic [STATE_W-1:0] INIT = STATE_W'(INIT_STATE);

    logic [STATE_W-1:0] state_q [N_TA];
    logic [STATE_W-1:0] state_d [N_TA];
    logic [N_TA-1:0]    sel;
    logic [N_TA-1:0]    flip_vec;
    logic               ready_q;
    logic               accept;
    logic               idx_bad;
    logic [15:0]        flip_pop;
    logic [16:0]        flip_sum;

    // ready_q keeps upd_ready low for the first cycle after reset release.
    assign upd_ready = ready_q & rst_n & ~freeze;
    assign accept    = upd_valid & upd_ready;
    assign idx_bad   = int'(upd_idx) >= N_TA;

    for (genvar i = 0; i < N_TA; i++) begin : g_ta
        assign sel[i]    = accept & (upd_bcast | (int'(upd_idx) == i));
        assign action[i] = state_q[i][STATE_W-1];

        tsetlin_next #(.STATE_W(STATE_W)) u_next (
            .state      (state_q[i]),
            .fb         (upd_fb),
            .en         (sel[i]),
            .next_state (state_d[i]),
            .flip       (flip_vec[i])
        );
    end

    assign flip_pop = popcount(MAX_TA'(flip_vec));
    assign flip_sum = {1'b0, flip_cnt} + {1'b0, flip_pop};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < N_TA; i++) state_q[i] <= INIT;
            ready_q  <= 1'b0;
            upd_err  <= 1'b0;
            flip_cnt <= '0;
        end else begin
            for (int i = 0; i < N_TA; i++) state_q[i] <= state_d[i];
            ready_q  <= 1'b1;
            upd_err  <= accept & ~upd_bcast & idx_bad;
            flip_cnt <= flip_sum[16] ? 16'hFFFF : flip_sum[15:0];
        end
    end

    always_comb begin
        rd_state = '0;
        for (int i = 0; i < N_TA; i++) begin
            if (int'(rd_idx) == i) rd_state = state_q[i];
        end
    end

endmodule

// File: tb/tb_tsetlin_bank.sv
// Self-checking bench for tsetlin_bank. It drives a 4-automaton and a
// 5-automaton instance in parallel and compares both against an abstract model.
module tb_tsetlin_bank;

    localparam int HALF = 4;
    localparam int MAXS = 7;
    localparam int INIT = 3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       upd_valid;
    logic       upd_bcast;
    logic [1:0] upd_fb;
    logic       freeze;
    logic [2:0] idx3;
    logic [2:0] rd3;

    logic        rdy4, rdy5, err4, err5;
    logic [3:0]  act4;
    logic [4:0]  act5;
    logic [2:0]  rs4, rs5;
    logic [15:0] fc4, fc5;

    int n_tests = 0;
    int n_fail  = 0;

    int m4 [4];
    int m5 [5];
    int fcm4, fcm5;
    bit errm5;
    bit rq;

    always #5 clk = ~clk;

    tsetlin_bank dut4 (
        .clk(clk), .rst_n(rst_n), .upd_valid(upd_valid), .upd_ready(rdy4),
        .upd_idx(idx3[1:0]), .upd_bcast(upd_bcast), .upd_fb(upd_fb),
        .freeze(freeze), .action(act4), .rd_idx(rd3[1:0]), .rd_state(rs4),
        .upd_err(err4), .flip_cnt(fc4)
    );

    tsetlin_bank #(.N_TA(5)) dut5 (
        .clk(clk), .rst_n(rst_n), .upd_valid(upd_valid), .upd_ready(rdy5),
        .upd_idx(idx3), .upd_bcast(upd_bcast), .upd_fb(upd_fb),
        .freeze(freeze), .action(act5), .rd_idx(rd3), .rd_state(rs5),
        .upd_err(err5), .flip_cnt(fc5)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference rules written directly from the automaton definition.
    function automatic int ta_next(input int s, input logic [1:0] fb);
        bit inc;
        inc = (s >= HALF);
        if (fb == 2'b01) return inc ? ((s + 1 > MAXS) ? MAXS : s + 1) : ((s - 1 < 0) ? 0 : s - 1);
        if (fb == 2'b10) return inc ? s - 1 : s + 1;
        return s;
    endfunction

    function automatic int sat_add(input int a, input int b);
        return (a + b > 65535) ? 65535 : a + b;
    endfunction

    task automatic model_reset();
        foreach (m4[j]) m4[j] = INIT;
        foreach (m5[j]) m5[j] = INIT;
        fcm4 = 0; fcm5 = 0; errm5 = 0; rq = 0;
    endtask

    task automatic cyc(input bit v, input bit bc, input logic [1:0] fb, input logic [2:0] idx,
                       input bit fz, input bit rn, input logic [2:0] ri);
        bit rdy_exp, acc;
        int ns, fl;
        logic [3:0] ea4;
        logic [4:0] ea5;
        upd_valid = v; upd_bcast = bc; upd_fb = fb; idx3 = idx;
        freeze = fz; rst_n = rn; rd3 = ri;
        #1;
        rdy_exp = rq && rn && !fz;
        chk("ready4", {31'b0, rdy4}, {31'b0, rdy_exp});
        chk("ready5", {31'b0, rdy5}, {31'b0, rdy_exp});
        chk("rd4", {29'b0, rs4}, m4[ri[1:0]]);
        chk("rd5", {29'b0, rs5}, (ri < 5) ? m5[ri] : 0);
        acc = v && rdy_exp;
        @(posedge clk);
        if (!rn) begin
            model_reset();
        end else begin
            rq = 1;
            errm5 = acc && !bc && (idx >= 5);
            if (acc) begin
                fl = 0;
                for (int j = 0; j < 4; j++) begin
                    if (bc || j == int'(idx[1:0])) begin
                        ns = ta_next(m4[j], fb);
                        if ((ns >= HALF) != (m4[j] >= HALF)) fl++;
                        m4[j] = ns;
                    end
                end
                fcm4 = sat_add(fcm4, fl);
                fl = 0;
                for (int j = 0; j < 5; j++) begin
                    if (bc || j == int'(idx)) begin
                        ns = ta_next(m5[j], fb);
                        if ((ns >= HALF) != (m5[j] >= HALF)) fl++;
                        m5[j] = ns;
                    end
                end
                fcm5 = sat_add(fcm5, fl);
            end
        end
        #1;
        for (int j = 0; j < 4; j++) ea4[j] = (m4[j] >= HALF);
        for (int j = 0; j < 5; j++) ea5[j] = (m5[j] >= HALF);
        chk("action4", {28'b0, act4}, {28'b0, ea4});
        chk("action5", {27'b0, act5}, {27'b0, ea5});
        chk("flip4", {16'b0, fc4}, fcm4);
        chk("flip5", {16'b0, fc5}, fcm5);
        chk("err4", {31'b0, err4}, 0);
        chk("err5", {31'b0, err5}, {31'b0, errm5});
    endtask

    task automatic idle(input bit rn);
        cyc(0, 0, 2'b00, 3'd0, 0, rn, 3'd0);
    endtask

    initial begin
        model_reset();
        upd_valid = 0; upd_bcast = 0; upd_fb = 0; freeze = 0; idx3 = 0; rd3 = 0; rst_n = 0;
        @(posedge clk); #1;

        // reset behaviour
        idle(0); idle(0);
        chk("rst_action", {28'b0, act4}, 0);
        chk("rst_flip", {16'b0, fc4}, 0);
        idle(1);
        chk("rdy_after_rst", {31'b0, rdy4}, 1);

        // penalty crossing in both directions
        cyc(1, 0, 2'b10, 3'd1, 0, 1, 3'd1);
        chk("pen1_action", {28'b0, act4}, 32'h2);
        chk("pen1_flip", {16'b0, fc4}, 1);
        cyc(1, 0, 2'b10, 3'd1, 0, 1, 3'd1);
        chk("pen2_action", {28'b0, act4}, 0);
        chk("pen2_flip", {16'b0, fc4}, 2);

        // reward saturation at 0 and at MAX
        repeat (4) cyc(1, 0, 2'b01, 3'd0, 0, 1, 3'd0);
        rd3 = 0; #1;
        chk("sat_zero", {29'b0, rs4}, 0);
        cyc(1, 0, 2'b10, 3'd2, 0, 1, 3'd2);
        repeat (4) cyc(1, 0, 2'b01, 3'd2, 0, 1, 3'd2);
        rd3 = 2; #1;
        chk("sat_max", {29'b0, rs4}, 7);
        chk("sat_flip", {16'b0, fc4}, 3);

        // broadcast from reset, back to back
        idle(0); idle(1);
        cyc(1, 1, 2'b10, 3'd2, 0, 1, 3'd0);
        chk("bc_action", {28'b0, act4}, 32'hF);
        chk("bc_flip", {16'b0, fc4}, 4);
        cyc(1, 1, 2'b01, 3'd0, 0, 1, 3'd0);
        for (int j = 0; j < 4; j++) begin
            rd3 = 3'(j); #1;
            chk("bc_reward_state", {29'b0, rs4}, 5);
        end
        chk("bc_reward_flip", {16'b0, fc4}, 4);

        // out-of-range index, no-op code still flags
        cyc(1, 0, 2'b00, 3'd6, 0, 1, 3'd4);
        chk("err_pulse", {31'b0, err5}, 1);
        cyc(1, 0, 2'b10, 3'd7, 0, 1, 3'd4);
        chk("err_pen_pulse", {31'b0, err5}, 1);
        idle(1);
        chk("err_clear", {31'b0, err5}, 0);

        // freeze blocks acceptance
        cyc(1, 1, 2'b10, 3'd0, 1, 1, 3'd0);
        chk("frz_flip", {16'b0, fc4}, 4);
        cyc(1, 0, 2'b10, 3'd0, 1, 1, 3'd0);

        // reset coinciding with a valid penalty
        cyc(1, 0, 2'b10, 3'd0, 0, 0, 3'd0);
        rd3 = 0; #1;
        chk("midrst_state", {29'b0, rs4}, 3);
        idle(1);

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            cyc(($urandom_range(0, 3) != 0), ($urandom_range(0, 7) == 0),
                2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
                ($urandom_range(0, 15) == 0), ($urandom_range(0, 99) != 0),
                3'($urandom_range(0, 7)));
        end

        // drive flip_cnt to 0xFFFE, then saturate
        idle(0); idle(1);
        for (int n = 0; n < 16383; n++) cyc(1, 1, 2'b10, 3'd0, 0, 1, 3'd0);
        chk("pre_sat_flip", {16'b0, fc4}, 32'hFFFC);
        cyc(1, 0, 2'b10, 3'd0, 0, 1, 3'd0);
        cyc(1, 0, 2'b10, 3'd0, 0, 1, 3'd0);
        chk("fffe_flip", {16'b0, fc4}, 32'hFFFE);
        cyc(1, 1, 2'b10, 3'd0, 0, 1, 3'd0);
        chk("sat_flip_cnt", {16'b0, fc4}, 32'hFFFF);
        cyc(1, 1, 2'b10, 3'd0, 0, 1, 3'd0);
        chk("sat_hold", {16'b0, fc4}, 32'hFFFF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
